alu_result_fifo: RTL

//  Downstream stage of the 8-bit ALU. Captures each ALU result F together with its
//  3-bit opcode {S2,S[1:0]} and buffers it in a DEPTH-entry FIFO.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_result_fifo_if.sv | 26 ++
 rtl/alu_flag_gen.sv | 13 +
 rtl/alu_result_fifo.sv | 60 ++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode type, opcode values and result-flag bit positions.
package alu_pkg;
    typedef logic [2:0] alu_op_t;
    localparam alu_op_t OP_ADD = 3'b000;
    localparam alu_op_t OP_SUB = 3'b001;
    localparam alu_op_t OP_INC = 3'b010;
    localparam alu_op_t OP_DEC = 3'b011;
    localparam alu_op_t OP_AND = 3'b100;
    localparam alu_op_t OP_OR  = 3'b101;
    localparam alu_op_t OP_XOR = 3'b110;
    localparam alu_op_t OP_NOT = 3'b111;
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_PAR  = 2;
endpackage

// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: producer/consumer handshake bundle of the ALU result FIFO.
interface alu_result_fifo_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_F;
    alu_op_t                in_op;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_F;
    alu_op_t                out_op;
    logic [2:0]             out_flags;
    logic [$clog2(DEPTH):0] count;
    modport master (
        output in_valid, in_F, in_op, out_ready,
        input  in_ready, out_valid, out_F, out_op, out_flags, count
    );
    modport slave (
        input  in_valid, in_F, in_op, out_ready,
        output in_ready, out_valid, out_F, out_op, out_flags, count
    );
endinterface

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: zero/negative/parity flags of an ALU result.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] f,
    output logic [2:0]       flags
);
    assign flags[FLAG_ZERO] = f == '0;
    assign flags[FLAG_NEG]  = f[WIDTH-1];
    assign flags[FLAG_PAR]  = ^f;
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word fall-through FIFO buffering ALU results and opcodes.
// Define ALU_RESULT_FLAGS_EN to store and present {parity,neg,zero} per entry.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    alu_result_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef ALU_RESULT_FLAGS_EN
    localparam int EW = WIDTH + 6;
`else
    localparam int EW = WIDTH + 3;
`endif
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wdata, head, head_q;
    logic [AW-1:0] wr_ptr, rd_ptr, nxt_rd;
    logic [AW:0]   count_q, nxt_count;
    logic          push, pop;
`ifdef ALU_RESULT_FLAGS_EN
    logic [2:0] in_flags;
    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (.f(bus.in_F), .flags(in_flags));
    assign wdata         = {in_flags, bus.in_op, bus.in_F};
    assign bus.out_flags = head_q[WIDTH+3 +: 3];
`else
    assign wdata         = {bus.in_op, bus.in_F};
    assign bus.out_flags = '0;
`endif
    assign bus.in_ready  = count_q != FULL_CNT;
    assign bus.out_valid = count_q != '0;
    assign bus.out_F     = head_q[WIDTH-1:0];
    assign bus.out_op    = head_q[WIDTH +: 3];
    assign bus.count     = count_q;
    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = bus.out_valid && bus.out_ready;
    assign nxt_rd    = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign nxt_count = count_q + (AW+1)'(push) - (AW+1)'(pop);
    // The next head is the incoming word when it lands in the slot about to be read.
    assign head = (push && wr_ptr == nxt_rd) ? wdata : mem[nxt_rd];
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
    // Output register holds the last popped entry once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wr_ptr  <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr  <= nxt_rd;
            count_q <= nxt_count;
            if (nxt_count != '0) head_q <= head;
        end
endmodule
